sig_a_pattern_gen: RTL and testbench

- Stimulus-side counterpart of the falling-edge checkers on sig_a.
- Accepts a bit pattern over a valid/ready handshake and drives it MSB-first onto sig_a, holding each bit for a programmable number of cycles.
- Emits a registered fall_strobe aligned with every 1->0 transition of sig_a, and keeps a saturating count of falls.
- Benches and checkers use fall_strobe as the expected $fell(sig_a) reference.

---
 rtl/sig_a_pattern_gen_if.sv | 24 ++
 rtl/sig_a_pattern_gen.sv | 138 +++++++++++++
 tb/tb_sig_a_pattern_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sig_a_pattern_gen_if.sv
// Pattern offer channel: valid/ready handshake plus the pattern descriptor.
interface sig_a_pattern_gen_if #(
    parameter int unsigned PAT_W  = 16,
    parameter int unsigned HOLD_W = 4
);
    localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

    logic              start_valid;
    logic              start_ready;
    logic [PAT_W-1:0]  pattern;
    logic [LEN_W-1:0]  length;
    logic [HOLD_W-1:0] hold;
    logic              idle_level;

    modport master (
        output start_valid, pattern, length, hold, idle_level,
        input  start_ready
    );

    modport slave (
        input  start_valid, pattern, length, hold, idle_level,
        output start_ready
    );
endinterface

// File: rtl/sig_a_pattern_gen.sv
// Drives an accepted bit pattern MSB-first onto sig_a with a per-bit hold,
// and emits a registered fall_strobe plus a saturating fall count.
module sig_a_pattern_gen #(
    parameter int unsigned PAT_W  = 16,
    parameter int unsigned HOLD_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    sig_a_pattern_gen_if.slave start,
    input  logic               clear_count,
    output logic               sig_a,
    output logic               busy,
    output logic               done,
    output logic               fall_strobe,
    output logic [CNT_W-1:0]   fall_count
);
    localparam int unsigned LEN_W = $clog2(PAT_W) + 1;
    localparam int unsigned IDX_W = $clog2(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [HOLD_W-1:0]  hcnt_q, hcnt_d;
    logic               idle_q, idle_d;
    logic               sig_a_d, busy_d, done_d, fall_d;
    logic [CNT_W-1:0]   count_d;

    logic               accept;
    logic [LEN_W-1:0]   eff_len;
    logic [IDX_W-1:0]   first_idx;
    logic [IDX_W-1:0]   idx_dec;
    logic               bit_end;
    logic               last_bit;

    // Zero and oversize lengths both mean a full-width pattern
    assign eff_len   = (start.length == '0 || start.length > LEN_W'(PAT_W))
                     ? LEN_W'(PAT_W) : start.length;
    assign first_idx = IDX_W'(eff_len - LEN_W'(1));
    assign idx_dec   = idx_q - IDX_W'(1);
    assign bit_end   = (hcnt_q == '0);
    assign last_bit  = bit_end && (idx_q == '0);

    assign start.start_ready = (state_q == IDLE);
    assign accept            = start.start_valid && (state_q == IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept)   state_d = DRIVE;
            DRIVE: if (last_bit) state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        pat_d   = pat_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        hcnt_d  = hcnt_q;
        idle_d  = idle_q;
        sig_a_d = sig_a;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                sig_a_d = idle_q;
                if (accept) begin
                    pat_d   = start.pattern;
                    idx_d   = first_idx;
                    hold_d  = start.hold;
                    hcnt_d  = start.hold;
                    idle_d  = start.idle_level;
                    sig_a_d = start.pattern[first_idx];
                end
            end
            DRIVE: begin
                if (!bit_end) begin
                    hcnt_d  = hcnt_q - HOLD_W'(1);
                    sig_a_d = pat_q[idx_q];
                end else if (idx_q != '0) begin
                    idx_d   = idx_dec;
                    hcnt_d  = hold_q;
                    sig_a_d = pat_q[idx_dec];
                end else begin
                    sig_a_d = idle_q;
                    done_d  = 1'b1;
                end
            end
        endcase
        busy_d = (state_d == DRIVE);
        fall_d = sig_a & ~sig_a_d;
        // Clear wins over a coincident fall
        if (clear_count)
            count_d = '0;
        else if (fall_strobe && fall_count != CNT_MAX)
            count_d = fall_count + CNT_W'(1);
        else
            count_d = fall_count;
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q       <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
            hcnt_q      <= '0;
            idle_q      <= 1'b0;
            sig_a       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fall_strobe <= 1'b0;
            fall_count  <= '0;
        end else begin
            pat_q       <= pat_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            hcnt_q      <= hcnt_d;
            idle_q      <= idle_d;
            sig_a       <= sig_a_d;
            busy        <= busy_d;
            done        <= done_d;
            fall_strobe <= fall_d;
            fall_count  <= count_d;
        end
    end
endmodule

// File: tb/tb_sig_a_pattern_gen.sv
// Directed bench for sig_a_pattern_gen: vector table plus handshake, reset
// and counter-saturation sequences.
module tb_sig_a_pattern_gen;
    logic clk;
    logic rst;
    logic clear_count;
    logic sig_a, busy, done, fall_strobe;
    logic [7:0] fall_count;

    logic sat_clear;
    logic sat_sig, sat_busy, sat_done, sat_fall;
    logic [1:0] sat_count;

    int n_tests = 0;
    int n_fail  = 0;

    sig_a_pattern_gen_if #(.PAT_W(16), .HOLD_W(4)) bus ();
    sig_a_pattern_gen_if #(.PAT_W(16), .HOLD_W(4)) sat_bus ();

    sig_a_pattern_gen #(.PAT_W(16), .HOLD_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(bus), .clear_count(clear_count),
        .sig_a(sig_a), .busy(busy), .done(done),
        .fall_strobe(fall_strobe), .fall_count(fall_count)
    );

    sig_a_pattern_gen #(.PAT_W(16), .HOLD_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(sat_bus), .clear_count(sat_clear),
        .sig_a(sat_sig), .busy(sat_busy), .done(sat_done),
        .fall_strobe(sat_fall), .fall_count(sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] pattern;
        logic [4:0]  length;
        logic [3:0]  hold;
        logic        idle;
        int          ncyc;      // cycles from first bit through the done cycle
        logic [31:0] exp_sig;   // bit [ncyc-c] is sig_a in cycle c
        logic [31:0] exp_fall;
        int          exp_count; // fall_count one cycle after done
    } vec_t;

    vec_t vecs[7];
    vec_t rv;

    task automatic check(input string name, input int cyc,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after done
    task automatic run_vec(input vec_t v, input int id);
        bus.start_valid = 1'b1;
        bus.pattern     = v.pattern;
        bus.length      = v.length;
        bus.hold        = v.hold;
        bus.idle_level  = v.idle;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        for (int c = 1; c <= v.ncyc; c++) begin
            check($sformatf("v%0d sig_a", id), c, 32'(sig_a), 32'(v.exp_sig[v.ncyc - c]));
            check($sformatf("v%0d fall_strobe", id), c, 32'(fall_strobe), 32'(v.exp_fall[v.ncyc - c]));
            check($sformatf("v%0d done", id), c, 32'(done), 32'(c == v.ncyc));
            check($sformatf("v%0d busy", id), c, 32'(busy), 32'(c < v.ncyc));
            check($sformatf("v%0d start_ready", id), c, 32'(bus.start_ready), 32'(c == v.ncyc));
            @(posedge clk); #1;
        end
        check($sformatf("v%0d fall_count", id), v.ncyc + 1, 32'(fall_count), 32'(v.exp_count));
        check($sformatf("v%0d done_after", id), v.ncyc + 1, 32'(done), 32'd0);
    endtask

    logic [9:0] hs_sig, hs_fall, hs_done, hs_busy;

    initial begin
        vecs[0] = '{16'h00A5, 5'd8,  4'd0,  1'b0, 9,  32'b101001010, 32'b010100101, 4};
        vecs[1] = '{16'h0002, 5'd2,  4'd2,  1'b0, 7,  32'b1110000,   32'b0001000,   5};
        vecs[2] = '{16'hFFFF, 5'd0,  4'd0,  1'b1, 17, 32'h1FFFF,     32'h0,         5};
        vecs[3] = '{16'h0001, 5'd3,  4'd1,  1'b0, 7,  32'b0000110,   32'b1000001,   7};
        vecs[4] = '{16'h8000, 5'd20, 4'd0,  1'b0, 17, 32'h10000,     32'h08000,     8};
        vecs[5] = '{16'h0001, 5'd1,  4'd15, 1'b1, 17, 32'h1FFFF,     32'h0,         8};
        vecs[6] = '{16'h0000, 5'd1,  4'd0,  1'b0, 2,  32'b00,        32'b10,        9};

        rst = 1'b0;
        clear_count = 1'b0;
        sat_clear = 1'b0;
        bus.start_valid = 1'b0; bus.pattern = '0; bus.length = '0; bus.hold = '0; bus.idle_level = 1'b0;
        sat_bus.start_valid = 1'b0; sat_bus.pattern = '0; sat_bus.length = '0; sat_bus.hold = '0;
        sat_bus.idle_level = 1'b0;

        #12;
        check("rst sig_a", 0, 32'(sig_a), 32'd0);
        check("rst busy", 0, 32'(busy), 32'd0);
        check("rst done", 0, 32'(done), 32'd0);
        check("rst fall_strobe", 0, 32'(fall_strobe), 32'd0);
        check("rst fall_count", 0, 32'(fall_count), 32'd0);
        check("rst start_ready", 0, 32'(bus.start_ready), 32'd1);
        #8 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Back-to-back: start_valid held high, second pattern taken in the done cycle
        hs_sig  = 10'b1010011111;
        hs_fall = 10'b0101000000;
        hs_done = 10'b0000100001;
        hs_busy = 10'b1111011110;
        bus.start_valid = 1'b1;
        bus.pattern = 16'h000A; bus.length = 5'd4; bus.hold = 4'd0; bus.idle_level = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= 10; c++) begin
            check("hs sig_a", c, 32'(sig_a), 32'(hs_sig[10 - c]));
            check("hs fall_strobe", c, 32'(fall_strobe), 32'(hs_fall[10 - c]));
            check("hs done", c, 32'(done), 32'(hs_done[10 - c]));
            check("hs busy", c, 32'(busy), 32'(hs_busy[10 - c]));
            check("hs start_ready", c, 32'(bus.start_ready), 32'(hs_done[10 - c]));
            if (c == 1) begin
                bus.pattern = 16'h000F; bus.idle_level = 1'b1;
            end
            if (c == 6) bus.start_valid = 1'b0;
            @(posedge clk); #1;
        end
        check("hs fall_count", 11, 32'(fall_count), 32'd11);

        // Asynchronous reset during the third bit
        bus.start_valid = 1'b1;
        bus.pattern = 16'h00FF; bus.length = 5'd8; bus.hold = 4'd0; bus.idle_level = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstmid pre busy", 3, 32'(busy), 32'd1);
        check("rstmid pre sig_a", 3, 32'(sig_a), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstmid sig_a", 3, 32'(sig_a), 32'd0);
        check("rstmid busy", 3, 32'(busy), 32'd0);
        check("rstmid fall_count", 3, 32'(fall_count), 32'd0);
        check("rstmid fall_strobe", 3, 32'(fall_strobe), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("rstpost done", c, 32'(done), 32'd0);
            check("rstpost fall_strobe", c, 32'(fall_strobe), 32'd0);
            check("rstpost sig_a", c, 32'(sig_a), 32'd0);
        end
        rv = vecs[0];
        rv.exp_count = 4;
        run_vec(rv, 7);

        // Two-bit counter: saturation, then clear coincident with a fall
        sat_bus.start_valid = 1'b1;
        sat_bus.pattern = 16'hAAAA; sat_bus.length = 5'd16; sat_bus.hold = 4'd0; sat_bus.idle_level = 1'b0;
        @(posedge clk); #1;
        sat_bus.start_valid = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            if (c == 7 || c == 9 || c == 17)
                check("sat fall_count", c, 32'(sat_count), 32'd3);
            if (c == 17)
                check("sat done", c, 32'(sat_done), 32'd1);
            @(posedge clk); #1;
        end
        sat_bus.start_valid = 1'b1;
        @(posedge clk); #1;
        sat_bus.start_valid = 1'b0;
        check("clr pre count", 1, 32'(sat_count), 32'd3);
        @(posedge clk); #1;
        check("clr fall_strobe", 2, 32'(sat_fall), 32'd1);
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        check("clr count", 3, 32'(sat_count), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("clr recount", 5, 32'(sat_count), 32'd1);
        for (int c = 6; c <= 18; c++) begin
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
